// File: rtl/router_pkg.sv
// Shared router/tile types and the XY dimension-order direction helper.
package router_pkg;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } t_tile_id;

  typedef enum logic [1:0] {
    WR     = 2'd0,
    RD     = 2'd1,
    RD_RSP = 2'd2
  } t_trans_type;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    t_trans_type opcode;
    t_tile_id    requestor_id;
  } t_tile_trans;

  typedef struct packed {
    logic north_arb;
    logic east_arb;
    logic west_arb;
    logic south_arb;
  } t_fab_ready;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RSP_SEND = 2'd2
  } t_rsp_state;

  // One-hot output arbiter selection; all-zero means the destination is this tile.
  function automatic t_fab_ready xy_dir(input t_tile_id dest, input t_tile_id local_id);
    xy_dir = '0;
    if (dest.x > local_id.x)      xy_dir.east_arb  = 1'b1;
    else if (dest.x < local_id.x) xy_dir.west_arb  = 1'b1;
    else if (dest.y > local_id.y) xy_dir.south_arb = 1'b1;
    else if (dest.y < local_id.y) xy_dir.north_arb = 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mini_core_local_fifo.sv
// Small show-ahead synchronous FIFO used as the responder's ingress buffer.
module mini_core_local_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rdata = store[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)  wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop  && !empty) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mini_core_local_responder.sv
// Tile-local endpoint: services WR/RD from the router's local port and injects RD_RSP.
// Optional MINI_CORE_LOCAL_RSP_ADDR_CHK_EN adds out-of-range checking and err_cnt.
module mini_core_local_responder
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  t_tile_id    local_tile_id,
  input  logic        out_local_req_valid,
  input  t_tile_trans out_local_req,
  output t_fab_ready  in_local_ready,
  output logic        in_local_req_valid,
  output t_tile_trans in_local_req,
  input  t_fab_ready  out_local_ready,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] rsp_cnt
`ifdef MINI_CORE_LOCAL_RSP_ADDR_CHK_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int TRANS_W = $bits(t_tile_trans);

  t_rsp_state           state_reg, state_next;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [TRANS_W-1:0]   head_bits;
  t_tile_trans          head;
  logic [IDX_W-1:0]     head_idx;
  logic                 head_oor;
  logic                 mem_we, rd_issue, wr_inc, rsp_inc, rd_done, rsp_load;
  logic [31:0]          mem [MEM_WORDS];
  logic [31:0]          rd_data_reg;
  logic [31:0]          rsp_data;
  logic [23:0]          rd_addr_reg;
  t_tile_id             rd_req_reg;
  t_fab_ready           rsp_dir;

  assign fifo_push      = out_local_req_valid && !fifo_full;
  assign in_local_ready = t_fab_ready'({4{~fifo_full}});

  mini_core_local_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRANS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (out_local_req),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head     = t_tile_trans'(head_bits);
  assign head_idx = head.address[IDX_W+1:2];
  assign rsp_dir  = xy_dir(rd_req_reg, local_tile_id);

`ifdef MINI_CORE_LOCAL_RSP_ADDR_CHK_EN
  logic rd_oor_reg;
  assign head_oor = (head.address[23:0] >= 24'(MEM_WORDS * 4));
  assign rsp_data = rd_oor_reg ? 32'hDEAD_BEEF : rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oor_reg <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (rd_issue) rd_oor_reg <= head_oor;
      if (fifo_pop && head_oor && (head.opcode == WR || head.opcode == RD))
        err_cnt <= sat_inc16(err_cnt);
    end
  end
`else
  assign head_oor = 1'b0;
  assign rsp_data = rd_data_reg;
`endif

  // The destination byte was already consumed by the router when it ejected to us.
  logic unused_dest;
  assign unused_dest = &{1'b0, head.address[31:24]};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    mem_we     = 1'b0;
    rd_issue   = 1'b0;
    wr_inc     = 1'b0;
    rsp_inc    = 1'b0;
    rd_done    = 1'b0;
    rsp_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (head.opcode)
            WR: begin
              mem_we = !head_oor;
              wr_inc = !head_oor;
            end
            RD: begin
              rd_issue   = 1'b1;
              state_next = RD_WAIT;
            end
            RD_RSP:  rsp_inc = 1'b1;
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (rsp_dir == '0) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end else begin
          rsp_load   = 1'b1;
          state_next = RSP_SEND;
        end
      end
      RSP_SEND: begin
        if (|(4'(rsp_dir) & 4'(out_local_ready))) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory kept reset-free with a registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we)   mem[head_idx] <= head.data;
    if (rd_issue) rd_data_reg   <= mem[head_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_reg        <= '0;
      rd_req_reg         <= '0;
      in_local_req_valid <= 1'b0;
      in_local_req       <= '0;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      rsp_cnt            <= '0;
    end else begin
      if (rd_issue) begin
        rd_addr_reg <= head.address[23:0];
        rd_req_reg  <= head.requestor_id;
      end
      if (rsp_load) begin
        in_local_req_valid        <= 1'b1;
        in_local_req.address      <= {rd_req_reg, rd_addr_reg};
        in_local_req.data         <= rsp_data;
        in_local_req.opcode       <= RD_RSP;
        in_local_req.requestor_id <= local_tile_id;
      end else if (state_reg == RSP_SEND && rd_done) begin
        in_local_req_valid <= 1'b0;
      end
      if (wr_inc)  wr_cnt  <= sat_inc16(wr_cnt);
      if (rd_done) rd_cnt  <= sat_inc16(rd_cnt);
      if (rsp_inc) rsp_cnt <= sat_inc16(rsp_cnt);
    end
  end

endmodule
